// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_ctrl
// Brief    : Sequencer for the conv line-buffer chain: accepts a raster pixel
//            stream, drives shift enable / frame clear, presents KxK windows.
//            Optional window counter output when CONV_WIN_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int KERNEL_SIZE = 3,
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1
`ifdef CONV_WIN_COUNT_EN
    ,
    localparam int CNT_W = $clog2(IMG_HEIGHT * IMG_WIDTH + 1)
`endif
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic             shift_en_o,
    output logic             shift_clr_o,
    output logic             win_valid_o,
    input  logic             win_ready_i,
    output logic [ROW_W-1:0] win_row_o,
    output logic [COL_W-1:0] win_col_o,
    output logic             busy_o,
    output logic             frame_done_o
`ifdef CONV_WIN_COUNT_EN
    ,
    output logic [CNT_W-1:0] win_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_ROW_OFS  = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0] c_COL_OFS  = COL_W'(KERNEL_SIZE - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_win_valid;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;
    logic             r_frame_done;

    logic w_start;
    logic w_pix_ready;
    logic w_accept;
    logic w_win_hs;
    logic w_win_hit;
    logic w_last_pix;
    logic w_frame_end;

    assign w_start     = (r_state == S_IDLE) && start_i;
    // A pending window blocks new pixels unless it is retired on this same edge.
    assign w_pix_ready = (r_state == S_STREAM) && (!r_win_valid || win_ready_i);
    assign w_accept    = pix_valid_i && w_pix_ready;
    assign w_win_hs    = r_win_valid && win_ready_i;
    assign w_win_hit   = (r_row >= c_ROW_OFS) && (r_col >= c_COL_OFS);
    assign w_last_pix  = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_frame_end = (r_state == S_FLUSH) && w_win_hs;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept && w_last_pix) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_win_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start || w_frame_end) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Window register: load on a completing pixel, else retire on handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (w_accept && w_win_hit) begin
            r_win_valid <= 1'b1;
            r_win_row   <= r_row - c_ROW_OFS;
            r_win_col   <= r_col - c_COL_OFS;
        end else if (win_ready_i) begin
            r_win_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
        end
    end

`ifdef CONV_WIN_COUNT_EN
    logic [CNT_W-1:0] r_win_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_win_count <= '0;
        end else if (w_win_hs) begin
            r_win_count <= r_win_count + 1'b1;
        end
    end

    assign win_count_o = r_win_count;
`endif

    assign pix_ready_o  = w_pix_ready;
    assign shift_en_o   = w_accept;
    assign shift_clr_o  = w_start;
    assign win_valid_o  = r_win_valid;
    assign win_row_o    = r_win_row;
    assign win_col_o    = r_win_col;
    assign busy_o       = (r_state != S_IDLE);
    assign frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencer for the convolution line-buffer chain built from the team's shift-register-with-store blocks.
- Accepts a raster pixel stream (valid/ready) and generates the shift enable and the frame-start clear for the chain.
- Tracks row/column position and flags when the stored taps form a complete KxK window.
- Sits between the image input FIFO and the conv MAC array; downstream backpressure stalls shifting, so the window contents stay stable while presented.

Parameters:
- ImgWidth, 28, pixels per row (>= KernelSize)
- ImgHeight, 28, rows per frame (>= KernelSize)
- KernelSize, 3, window edge K (>= 1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  begin a frame; sampled only in IDLE
- pix_valid_i  in  1  input pixel valid
- pix_ready_o  out  1  controller can accept a pixel this cycle
- shift_en_o  out  1  drives en_i of every shift register in the chain
- shift_clr_o  out  1  one-cycle pulse to clear the chain at frame start
- win_valid_o  out  1  chain holds a complete window
- win_ready_i  in  1  consumer takes the window
- win_row_o  out  $clog2(ImgHeight)  top-left row of the presented window
- win_col_o  out  $clog2(ImgWidth)  top-left column of the presented window
- busy_o  out  1  high in any state other than IDLE
- frame_done_o  out  1  one-cycle pulse after the last window is consumed

Behaviour:
- Reset (rst_i high at a clock edge): state=IDLE; row/col counters=0; win_valid_o=0; win_row_o=0; win_col_o=0; frame_done_o=0. Reset wins over every other input in the same cycle and may abort a frame at any point.
- States: IDLE, STREAM, FLUSH.
- IDLE:
  - pix_ready_o=0; busy_o=0.
  - start_i=1 asserts shift_clr_o combinationally in that same cycle. Next state is STREAM with row=col=0.
- STREAM:
  - pix_ready_o = !win_valid_o || win_ready_i (combinational).
  - A pixel is accepted when pix_valid_i && pix_ready_o. In that cycle shift_en_o=1; otherwise shift_en_o=0. The chain shifts only on accepted pixels.
  - On accept of the pixel at (row, col):
    - col increments, wrapping to 0 at ImgWidth-1, which increments row.
    - If row >= K-1 and col >= K-1, set win_valid_o=1 on the next cycle, with win_row_o=row-K+1 and win_col_o=col-K+1. Latency: 1 cycle from accept to win_valid_o.
    - If no window is produced, win_valid_o clears when win_ready_i is high.
  - An accept coinciding with a window handshake retires the old window and loads the new one in the same edge. This gives back-to-back windows at 1/cycle.
  - win_valid_o, win_row_o and win_col_o hold stable while win_valid_o=1 and win_ready_i=0.
  - Accept of pixel (ImgHeight-1, ImgWidth-1) -> FLUSH.
- FLUSH:
  - pix_ready_o=0.
  - Waits for the final window handshake (win_valid_o && win_ready_i).
  - Then frame_done_o=1 for exactly one cycle, counters reset to 0, next state IDLE.
- start_i outside IDLE is ignored. shift_clr_o is 0 outside IDLE.
- Windows per frame = (ImgHeight-K+1)*(ImgWidth-K+1), emitted in raster order.
- K=1: every accepted pixel produces a window.

Optional Feature:
- Macro CONV_WIN_COUNT_EN.
- Defined: adds output win_count_o, $clog2(ImgHeight*ImgWidth+1) bits.
  - Counts window handshakes in the current frame.
  - Cleared by reset and by start_i in IDLE.
  - Holds its value after frame_done_o until the next start.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- ImgWidth=5, ImgHeight=4, K=3, win_ready_i=1, pix_valid_i=1 continuously after start:
  - shift_clr_o pulses in the start cycle.
  - Exactly 6 windows, with (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - First win_valid_o 1 cycle after accepting pixel 12.
  - frame_done_o one cycle after the 6th window.
- Same config, win_ready_i held 0 for 4 cycles while the first window is presented:
  - pix_ready_o=0 and shift_en_o=0 for those cycles.
  - win_row_o/win_col_o stay (0,0).
  - No pixel lost.
- pix_valid_i toggling 1/0 each cycle: shift_en_o pulses only on accepted pixels; same 6 windows in order.
- rst_i asserted mid-frame after 9 pixels:
  - Next cycle IDLE, busy_o=0, win_valid_o=0.
  - A new start_i runs a full correct frame.
- start_i held high during STREAM: no shift_clr_o, no restart. K=1, 2x2 image: 4 windows, each 1 cycle after its pixel.
- With CONV_WIN_COUNT_EN, 5x4 K=3 frame: win_count_o=6 after frame_done_o; cleared to 0 on the next start_i.
